// File: rtl/cpu_state_dump_ctrl.sv
// End-of-run state dumper: halts the CPU, then streams register file, data memory words and flags.
// Optional trailing checksum record when DUMP_CHECKSUM_EN is defined.
module cpu_state_dump_ctrl #(
  parameter int DATA_W     = 64,
  parameter int NUM_REGS   = 32,
  parameter int MEM_BYTES  = 128,
  parameter int RUN_CYCLES = 1000,
  parameter int CNT_W      = 16
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         start,
  output logic                         halt_cpu,
  output logic [$clog2(NUM_REGS)-1:0]  rf_raddr,
  input  logic [DATA_W-1:0]            rf_rdata,
  output logic [$clog2(MEM_BYTES)-1:0] mem_raddr,
  input  logic [7:0]                   mem_rdata,
  input  logic [3:0]                   flags_in,
  output logic                         out_valid,
  input  logic                         out_ready,
  output logic [DATA_W-1:0]            out_data,
  output logic [1:0]                   out_tag,
  output logic [CNT_W-1:0]             out_index,
  output logic                         done
);
  localparam int BPW = DATA_W / 8;
  localparam int RAW = $clog2(NUM_REGS);
  localparam int MAW = $clog2(MEM_BYTES);
  localparam int BW  = (BPW > 1) ? $clog2(BPW) : 1;

  typedef enum logic [2:0] {S_RUN, S_REGS, S_MEM, S_FLAGS, S_CSUM, S_DRAIN, S_DONE} state_t;

  state_t             state, state_n;
  logic [CNT_W-1:0]   cnt;
  logic [RAW-1:0]     reg_idx;
  logic [MAW-1:0]     word_base;
  logic [BW-1:0]      byte_b;
  logic [DATA_W-1:0]  asm_word;
  logic               full;
  logic               slot_free;
  logic               ld;
  logic [DATA_W-1:0]  ld_data;
  logic [1:0]         ld_tag;
  logic [CNT_W-1:0]   ld_index;
`ifdef DUMP_CHECKSUM_EN
  logic [DATA_W-1:0]  csum;
`endif

  assign slot_free = !out_valid || out_ready;
  assign rf_raddr  = reg_idx;
  assign mem_raddr = word_base + MAW'(byte_b);
  assign done      = (state == S_DONE);

  always_comb begin
    state_n  = state;
    ld       = 1'b0;
    ld_data  = '0;
    ld_tag   = 2'd0;
    ld_index = '0;
    case (state)
      S_RUN:
        if (start || cnt == CNT_W'(RUN_CYCLES - 1)) state_n = S_REGS;
      S_REGS:
        if (slot_free) begin
          ld       = 1'b1;
          ld_data  = rf_rdata;
          ld_tag   = 2'd0;
          ld_index = CNT_W'(reg_idx);
          if (reg_idx == RAW'(NUM_REGS - 1)) state_n = S_MEM;
        end
      S_MEM:
        if (full && slot_free) begin
          ld       = 1'b1;
          ld_data  = asm_word;
          ld_tag   = 2'd1;
          ld_index = CNT_W'(word_base);
          if (word_base == MAW'(MEM_BYTES - BPW)) state_n = S_FLAGS;
        end
      S_FLAGS:
        if (slot_free) begin
          ld      = 1'b1;
          ld_data = DATA_W'(flags_in);
          ld_tag  = 2'd2;
`ifdef DUMP_CHECKSUM_EN
          state_n = S_CSUM;
`else
          state_n = S_DRAIN;
`endif
        end
`ifdef DUMP_CHECKSUM_EN
      S_CSUM:
        if (slot_free) begin
          ld      = 1'b1;
          ld_data = csum;
          ld_tag  = 2'd3;
          state_n = S_DRAIN;
        end
`endif
      S_DRAIN:
        if (slot_free) state_n = S_DONE;
      S_DONE: ;
      default: state_n = S_RUN;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= S_RUN;
      cnt       <= '0;
      halt_cpu  <= 1'b0;
      out_valid <= 1'b0;
      out_data  <= '0;
      out_tag   <= 2'd0;
      out_index <= '0;
      reg_idx   <= '0;
      word_base <= '0;
      byte_b    <= '0;
      asm_word  <= '0;
      full      <= 1'b0;
`ifdef DUMP_CHECKSUM_EN
      csum      <= '0;
`endif
    end else begin
      state <= state_n;
      // once out of RUN the CPU stays frozen until the next reset
      if (state_n != S_RUN) halt_cpu <= 1'b1;
      if (cnt != '1) cnt <= cnt + CNT_W'(1);

      if (ld) begin
        out_valid <= 1'b1;
        out_data  <= ld_data;
        out_tag   <= ld_tag;
        out_index <= ld_index;
      end else if (out_ready) begin
        out_valid <= 1'b0;
      end

      if (state == S_REGS && slot_free)
        reg_idx <= (reg_idx == RAW'(NUM_REGS - 1)) ? '0 : reg_idx + RAW'(1);

      // gather one byte per cycle, then hold the word until the slot frees
      if (state == S_MEM) begin
        if (!full) begin
          asm_word[{byte_b, 3'b000} +: 8] <= mem_rdata;
          if (byte_b == BW'(BPW - 1)) begin
            full   <= 1'b1;
            byte_b <= '0;
          end else begin
            byte_b <= byte_b + BW'(1);
          end
        end else if (slot_free) begin
          full      <= 1'b0;
          word_base <= word_base + MAW'(BPW);
        end
      end
`ifdef DUMP_CHECKSUM_EN
      if (ld) csum <= csum + ld_data;
`endif
    end
  end
endmodule
